// File: rtl/guess_pkg.sv
// -----------------------------------------------------------------------------
// guess_pkg
// Shared types and constants for the number-guessing round controller.
//   ctrl_state_t      : round sequencer states
//   LVL_TIME[1:3]     : seconds on the clock per difficulty level
//   DIGIT_LIMIT[1:3]  : exclusive upper bound of the secret per digit count
//   ROUNDS_PER_LEVEL  : rounds that must be won to finish a level
//   LFSR_W            : width of the secret-draw LFSR
// -----------------------------------------------------------------------------
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  localparam int LFSR_W           = 10;
  localparam int ROUNDS_PER_LEVEL = 5;

  // Index 1..3 are meaningful; index 0 ("no level") never reaches these tables.
  localparam logic [3:1][6:0] LVL_TIME    = {7'd90, 7'd60, 7'd30};
  localparam logic [3:1][9:0] DIGIT_LIMIT = {10'd1000, 10'd100, 10'd10};

  function automatic logic [6:0] level_time(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return LVL_TIME[1];
      2'd2:    return LVL_TIME[2];
      2'd3:    return LVL_TIME[3];
      default: return 7'd0;
    endcase
  endfunction

  // A digit count of 0 is not a legal input; treat it like a single digit.
  function automatic logic [9:0] digit_limit(input logic [1:0] digits);
    case (digits)
      2'd2:    return DIGIT_LIMIT[2];
      2'd3:    return DIGIT_LIMIT[3];
      default: return DIGIT_LIMIT[1];
    endcase
  endfunction

endpackage

// File: rtl/guess_lfsr.sv
// -----------------------------------------------------------------------------
// guess_lfsr
// Free-running Fibonacci LFSR, polynomial x^10 + x^7 + 1 (shift left, feedback
// into bit 0). Never produces zero when seeded with a nonzero value.
// Ports:
//   clk      : system clock
//   restart  : synchronous active-high reset, loads SEED
//   en       : advance one step this cycle
//   value    : current LFSR contents
// -----------------------------------------------------------------------------
module guess_lfsr #(
  parameter int                LFSR_W = 10,
  parameter int                TAP    = 7,
  parameter logic [LFSR_W-1:0] SEED   = 10'h2A5
) (
  input  logic              clk,
  input  logic              restart,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[TAP-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// guess_round_ctrl
// Round sequencer for the number-guessing game: draws a secret per round,
// runs the per-level countdown, judges guesses and counts misses and wins.
// Optional feature macro: GUESS_HINT_EN (too_high/too_low hints). When it is
// undefined both hint outputs are tied low and no magnitude compare exists.
// Ports:
//   clk               : system clock
//   restart           : synchronous active-high reset
//   confirm_btn       : debounced confirm level (synchronized + edge detected)
//   guess[9:0]        : player guess
//   diff_level[1:0]   : 0 = no game, 1..3 = level being played
//   max_incorrect[2:0]: miss limit for the level
//   max_digit[1:0]    : secret digit count (1..3)
//   timer[6:0]        : seconds remaining
//   incorrect_guesses : misses this level, saturating at 7
//   round[2:0]        : rounds won this level, saturating at 7
//   correct           : one-cycle pulse on a correct guess
//   too_high/too_low  : direction of the last wrong guess
// -----------------------------------------------------------------------------
module guess_round_ctrl
  import guess_pkg::*;
#(
  parameter int                TICK_DIV  = 50_000_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h2A5
) (
  input  logic       clk,
  input  logic       restart,
  input  logic       confirm_btn,
  input  logic [9:0] guess,
  input  logic [1:0] diff_level,
  input  logic [2:0] max_incorrect,
  input  logic [1:0] max_digit,
  output logic [6:0] timer,
  output logic [2:0] incorrect_guesses,
  output logic [2:0] round,
  output logic       correct,
  output logic       too_high,
  output logic       too_low
);

  localparam int                PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  ctrl_state_t        state_q, state_d;
  logic [1:0]         level_q, level_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [6:0]         timer_q, timer_d;
  logic [2:0]         inc_q, inc_d;
  logic [2:0]         round_q, round_d;
  logic               correct_q, correct_d;
  logic [9:0]         secret_q, secret_d;
  logic               sync1_q, sync2_q, conf_prev_q;

  logic [LFSR_W-1:0]  lfsr_val;
  logic [9:0]         candidate;
  logic               conf_edge;
  logic               tick;
  logic               guess_ok;
  logic [2:0]         inc_sat, round_sat;

  guess_lfsr #(
    .LFSR_W (LFSR_W),
    .TAP    (7),
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .restart (restart),
    .en      (1'b1),
    .value   (lfsr_val)
  );

  // LFSR never yields 0, so subtracting one makes 0 a reachable secret.
  assign candidate = lfsr_val - 10'd1;
  assign conf_edge = sync2_q & ~conf_prev_q;
  assign tick      = (presc_q == PRESC_MAX);
  assign guess_ok  = (guess == secret_q);
  assign inc_sat   = (inc_q == 3'd7)   ? 3'd7 : inc_q + 3'd1;
  assign round_sat = (round_q == 3'd7) ? 3'd7 : round_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    presc_d   = '0;
    timer_d   = timer_q;
    inc_d     = inc_q;
    round_d   = round_q;
    correct_d = 1'b0;
    secret_d  = secret_q;

    // Level changes outrank any confirm or tick in the same cycle.
    if (state_q != IDLE && diff_level == 2'd0) begin
      state_d = IDLE;
      round_d = '0;
      inc_d   = '0;
      timer_d = '0;
    end else if (state_q != IDLE && diff_level != level_q) begin
      state_d = LOAD;
      level_d = diff_level;
      round_d = '0;
      inc_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (diff_level != 2'd0) begin
            state_d = LOAD;
            level_d = diff_level;
            round_d = '0;
            inc_d   = '0;
          end
        end
        LOAD: begin
          // Rejection sampling: keep drawing until the value fits the digit range.
          if (candidate < digit_limit(max_digit)) begin
            secret_d = candidate;
            timer_d  = level_time(level_q);
            state_d  = PLAY;
          end
        end
        PLAY: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          if (conf_edge && guess_ok) begin
            // Reload wins over a coincident tick.
            correct_d = 1'b1;
            round_d   = round_sat;
            timer_d   = level_time(level_q);
            state_d   = (round_sat == 3'(ROUNDS_PER_LEVEL)) ? DONE : LOAD;
          end else begin
            if (conf_edge) begin
              inc_d = inc_sat;
              if (inc_sat >= max_incorrect) state_d = DONE;
            end
            if (tick && timer_q != 7'd0) begin
              timer_d = timer_q - 7'd1;
              if (timer_q == 7'd1) state_d = DONE;
            end
          end
        end
        DONE: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state_q     <= IDLE;
      level_q     <= '0;
      presc_q     <= '0;
      timer_q     <= '0;
      inc_q       <= '0;
      round_q     <= '0;
      correct_q   <= 1'b0;
      secret_q    <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      conf_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      presc_q     <= presc_d;
      timer_q     <= timer_d;
      inc_q       <= inc_d;
      round_q     <= round_d;
      correct_q   <= correct_d;
      secret_q    <= secret_d;
      sync1_q     <= confirm_btn;
      sync2_q     <= sync1_q;
      conf_prev_q <= sync2_q;
    end
  end

  assign timer             = timer_q;
  assign incorrect_guesses = inc_q;
  assign round             = round_q;
  assign correct           = correct_q;

`ifdef GUESS_HINT_EN
  logic too_high_q, too_high_d, too_low_q, too_low_d;

  // Hints are zero whenever a secret is being drawn or the game is idle, so
  // clearing on any cycle that lands in LOAD/IDLE covers every LOAD entry.
  // A PLAY confirm that does not leave for LOAD/IDLE and is not correct is a miss.
  always_comb begin
    too_high_d = too_high_q;
    too_low_d  = too_low_q;
    if (state_d == LOAD || state_d == IDLE || correct_d) begin
      too_high_d = 1'b0;
      too_low_d  = 1'b0;
    end else if (state_q == PLAY && conf_edge) begin
      too_high_d = (guess > secret_q);
      too_low_d  = (guess < secret_q);
    end
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      too_high_q <= 1'b0;
      too_low_q  <= 1'b0;
    end else begin
      too_high_q <= too_high_d;
      too_low_q  <= too_low_d;
    end
  end

  assign too_high = too_high_q;
  assign too_low  = too_low_q;
`else
  assign too_high = 1'b0;
  assign too_low  = 1'b0;
`endif

endmodule

// File: tb/tb_guess_round_ctrl.sv
`timescale 1ns/1ps
module tb_guess_round_ctrl;

  localparam int TICK_DIV = 4;
  localparam int SEED     = 'h2A5;

  // Bench-side game phases
  localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_DONE = 3;
  // Action kinds for the vector table
  localparam int K_START = 0, K_OK = 1, K_HI = 2, K_LO = 3, K_OVR = 4;

`ifdef GUESS_HINT_EN
  localparam bit HINTS = 1'b1;
`else
  localparam bit HINTS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       restart = 1'b1;
  logic       confirm_btn = 1'b0;
  logic [9:0] guess = '0;
  logic [1:0] diff_level = '0;
  logic [2:0] max_incorrect = 3'd7;
  logic [1:0] max_digit = 2'd1;
  logic [6:0] timer;
  logic [2:0] incorrect_guesses;
  logic [2:0] round;
  logic       correct, too_high, too_low;

  guess_round_ctrl #(.TICK_DIV(TICK_DIV), .LFSR_SEED(10'h2A5)) dut (
    .clk               (clk),
    .restart           (restart),
    .confirm_btn       (confirm_btn),
    .guess             (guess),
    .diff_level        (diff_level),
    .max_incorrect     (max_incorrect),
    .max_digit         (max_digit),
    .timer             (timer),
    .incorrect_guesses (incorrect_guesses),
    .round             (round),
    .correct           (correct),
    .too_high          (too_high),
    .too_low           (too_low)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int m_phase = P_IDLE, m_level = 0, m_timer = 0, m_inc = 0, m_round = 0;
  int m_secret = 0, m_presc = 0, m_lfsr = SEED;
  bit m_correct = 0, m_hi = 0, m_lo = 0;
  bit [2:0] m_hist = '0;   // sampled confirm levels, [0] newest

  function automatic int lfsr_step(input int v);
    return ((v << 1) & 1023) | (((v >> 9) ^ (v >> 6)) & 1);
  endfunction
  function automatic int lim_of(input int d);
    return (d == 2) ? 100 : (d == 3) ? 1000 : 10;
  endfunction
  function automatic int time_of(input int l);
    return l * 30;
  endfunction

  always @(posedge clk) begin : model
    bit ev;
    bit tk;
    int lf_pre;
    int g;
    ev     = m_hist[1] & ~m_hist[2];
    tk     = (m_phase == P_PLAY) && (m_presc == TICK_DIV - 1);
    lf_pre = m_lfsr;
    g      = int'(guess);
    m_correct = 1'b0;
    if (restart) begin
      m_phase = P_IDLE; m_level = 0; m_timer = 0; m_inc = 0; m_round = 0;
      m_secret = 0; m_presc = 0; m_lfsr = SEED; m_hi = 0; m_lo = 0; m_hist = '0;
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
      m_hist = {m_hist[1:0], confirm_btn};
      if (m_phase != P_IDLE && diff_level == 0) begin
        m_phase = P_IDLE; m_round = 0; m_inc = 0; m_timer = 0; m_hi = 0; m_lo = 0; m_presc = 0;
      end else if (m_phase != P_IDLE && int'(diff_level) != m_level) begin
        m_phase = P_LOAD; m_level = int'(diff_level); m_round = 0; m_inc = 0;
        m_hi = 0; m_lo = 0; m_presc = 0;
      end else begin
        case (m_phase)
          P_IDLE: if (diff_level != 0) begin
            m_phase = P_LOAD; m_level = int'(diff_level); m_round = 0; m_inc = 0; m_hi = 0; m_lo = 0;
          end
          P_LOAD: if (lf_pre - 1 < lim_of(int'(max_digit))) begin
            m_secret = lf_pre - 1; m_timer = time_of(m_level); m_presc = 0; m_phase = P_PLAY;
          end
          P_PLAY: begin
            m_presc = tk ? 0 : m_presc + 1;
            if (ev && g == m_secret) begin
              m_correct = 1'b1;
              m_round   = (m_round < 7) ? m_round + 1 : 7;
              m_hi = 0; m_lo = 0;
              m_timer   = time_of(m_level);
              m_phase   = (m_round == 5) ? P_DONE : P_LOAD;
            end else begin
              if (ev) begin
                m_inc = (m_inc < 7) ? m_inc + 1 : 7;
                if (HINTS) begin m_hi = (g > m_secret); m_lo = (g < m_secret); end
                if (m_inc >= int'(max_incorrect)) m_phase = P_DONE;
              end
              if (tk && m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) m_phase = P_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    total++;
    if (timer !== 7'(m_timer) || incorrect_guesses !== 3'(m_inc) || round !== 3'(m_round) ||
        correct !== m_correct || too_high !== m_hi || too_low !== m_lo) begin
      bad++;
      $display("FAIL cycle_model t=%0t dut{timer=%0d inc=%0d round=%0d corr=%0b hi=%0b lo=%0b} want{timer=%0d inc=%0d round=%0d corr=%0b hi=%0b lo=%0b}",
               $time, timer, incorrect_guesses, round, correct, too_high, too_low,
               m_timer, m_inc, m_round, m_correct, m_hi, m_lo);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_play();
    int n = 0;
    while (m_phase == P_LOAD && n < 3000) begin @(negedge clk); n++; end
    check("wait_play_timeout", int'(n < 3000), 1);
  endtask

  task automatic wait_tick_edge();
    int n = 0;
    while (!(m_phase == P_PLAY && m_timer == 1 && m_presc == 1) && n < 1000) begin
      @(negedge clk); n++;
    end
    check("tick_align_timeout", int'(n < 1000), 1);
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1; confirm_btn = 1'b0;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic start_level(input int lvl, input int dig, input int maxinc);
    diff_level = 2'(lvl); max_digit = 2'(dig); max_incorrect = 3'(maxinc);
    @(negedge clk);
    wait_play();
  endtask

  // Holds confirm for 4 cycles: only one evaluation may result.
  task automatic guess_action(input int kind, output int pulses);
    int s, g;
    wait_play();
    s = m_secret;
    case (kind)
      K_OK:    g = s;
      K_HI:    g = s + 1;
      K_LO:    g = (s > 0) ? s - 1 : s + 2;
      default: g = 1023;
    endcase
    guess = 10'(g);
    confirm_btn = 1'b1;
    pulses = 0;
    repeat (4) begin @(negedge clk); pulses += int'(correct === 1'b1); end
    confirm_btn = 1'b0;
    repeat (2) begin @(negedge clk); pulses += int'(correct === 1'b1); end
  endtask

  typedef struct {
    int kind; int lvl; int dig; int maxinc;
    int exp_inc; int exp_round; int exp_pulse; int exp_timer;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int pulses;
    int r;
    vecs[0]  = '{K_START, 1, 1, 7, 0, 0, 0, 30};
    vecs[1]  = '{K_OK,    0, 0, 0, 0, 1, 1, -1};
    vecs[2]  = '{K_HI,    0, 0, 0, 1, 1, 0, -1};
    vecs[3]  = '{K_OK,    0, 0, 0, 1, 2, 1, -1};
    vecs[4]  = '{K_LO,    0, 0, 0, 2, 2, 0, -1};
    vecs[5]  = '{K_OK,    0, 0, 0, 2, 3, 1, -1};
    vecs[6]  = '{K_OK,    0, 0, 0, 2, 4, 1, -1};
    vecs[7]  = '{K_OK,    0, 0, 0, 2, 5, 1, -1};
    vecs[8]  = '{K_OK,    0, 0, 0, 2, 5, 0, -1};
    vecs[9]  = '{K_START, 2, 2, 3, 0, 0, 0, 60};
    vecs[10] = '{K_HI,    0, 0, 0, 1, 0, 0, -1};
    vecs[11] = '{K_LO,    0, 0, 0, 2, 0, 0, -1};
    vecs[12] = '{K_OVR,   0, 0, 0, 3, 0, 0, -1};
    vecs[13] = '{K_OK,    0, 0, 0, 3, 0, 0, -1};
    vecs[14] = '{K_START, 3, 3, 7, 0, 0, 0, 90};
    vecs[15] = '{K_OK,    0, 0, 0, 0, 1, 1, -1};
    vecs[16] = '{K_OVR,   0, 0, 0, 1, 1, 0, -1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_timer", int'(timer), 0);
    check("rst_inc", int'(incorrect_guesses), 0);
    check("rst_round", int'(round), 0);
    check("rst_correct", int'(correct), 0);
    check("rst_hi", int'(too_high), 0);
    check("rst_lo", int'(too_low), 0);
    restart = 1'b0;

    // Table-driven level/round/miss sequence
    for (int i = 0; i < 17; i++) begin
      pulses = 0;
      if (vecs[i].kind == K_START) start_level(vecs[i].lvl, vecs[i].dig, vecs[i].maxinc);
      else guess_action(vecs[i].kind, pulses);
      check($sformatf("v%0d_inc", i), int'(incorrect_guesses), vecs[i].exp_inc);
      check($sformatf("v%0d_round", i), int'(round), vecs[i].exp_round);
      check($sformatf("v%0d_pulse", i), pulses, vecs[i].exp_pulse);
      if (vecs[i].exp_timer >= 0) check($sformatf("v%0d_timer", i), int'(timer), vecs[i].exp_timer);
      $display("vec %0d kind=%0d timer=%0d inc=%0d round=%0d pulses=%0d", i, vecs[i].kind,
               timer, incorrect_guesses, round, pulses);
    end

    // Timeout: 30 s at 4 cycles/s, then frozen in DONE
    do_restart();
    start_level(1, 1, 7);
    check("to_start", int'(timer), 30);
    repeat (119) @(negedge clk);
    check("to_last_sec", int'(timer), 1);
    @(negedge clk);
    check("to_zero", int'(timer), 0);
    repeat (10) @(negedge clk);
    check("to_hold", int'(timer), 0);
    $display("timeout run timer=%0d", timer);

    // Wrong guess coinciding with the final tick, then level change
    do_restart();
    start_level(1, 1, 7);
    wait_tick_edge();
    guess = 10'(m_secret + 1); confirm_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("tw_inc", int'(incorrect_guesses), 1);
    check("tw_timer", int'(timer), 0);
    confirm_btn = 1'b0;
    repeat (3) @(negedge clk);
    guess = 10'(m_secret); confirm_btn = 1'b1;
    repeat (4) @(negedge clk);
    confirm_btn = 1'b0;
    check("tw_done_round", int'(round), 0);
    check("tw_done_inc", int'(incorrect_guesses), 1);
    start_level(2, 1, 7);
    check("lc_timer", int'(timer), 60);
    check("lc_inc", int'(incorrect_guesses), 0);
    check("lc_round", int'(round), 0);
    $display("tick+wrong then level change timer=%0d inc=%0d", timer, incorrect_guesses);

    // Correct guess coinciding with the final tick: reload wins
    do_restart();
    start_level(1, 1, 7);
    wait_tick_edge();
    guess = 10'(m_secret); confirm_btn = 1'b1;
    repeat (3) @(negedge clk);
    check("tc_correct", int'(correct), 1);
    check("tc_timer", int'(timer), 30);
    check("tc_round", int'(round), 1);
    confirm_btn = 1'b0;
    repeat (2) @(negedge clk);
    $display("tick+correct timer=%0d round=%0d", timer, round);

    // Hint direction, then restart mid-play
    do_restart();
    start_level(3, 3, 7);
    guess_action(K_HI, pulses);
    check("h_hi", int'(too_high), int'(HINTS));
    check("h_lo", int'(too_low), 0);
    guess_action(K_LO, pulses);
    check("l_hi", int'(too_high), 0);
    check("l_lo", int'(too_low), int'(HINTS));
    restart = 1'b1;
    @(negedge clk);
    check("mr_timer", int'(timer), 0);
    check("mr_inc", int'(incorrect_guesses), 0);
    check("mr_round", int'(round), 0);
    check("mr_hints", int'(too_high) + int'(too_low), 0);
    restart = 1'b0;
    $display("restart mid-play timer=%0d inc=%0d", timer, incorrect_guesses);

    // Randomized stimulus, judged by the cycle model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      restart = (r < 2);
      if (r >= 2 && r < 7) diff_level = 2'($urandom_range(0, 3));
      if (r >= 7 && r < 11) begin
        max_digit = 2'($urandom_range(1, 3));
        max_incorrect = 3'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 3))
        0:       guess = 10'($urandom_range(0, 1023));
        1:       guess = 10'(m_secret + 1);
        2:       guess = 10'(m_secret - 1);
        default: guess = 10'(m_secret);
      endcase
      confirm_btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    restart = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
